ins_fetcher: RTL

Front end of the out-of-order core. It holds the PC, looks the PC up in a direct-mapped instruction cache, and on a miss fetches the word through the memory controller. It presents one instruction at a time to the decoder (inst_input/inst/inst_addr) and advances the PC to the decoder's next_PC when the decoder accepts. On rob_clear it redirects to the ROB-supplied PC.

---
 rtl/ins_fetcher_pkg.sv | 19 +
 rtl/ins_fetcher_if.sv | 33 +++
 rtl/ins_fetcher_icache_dm.sv | 51 +++++
 rtl/ins_fetcher.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ins_fetcher_pkg.sv
// ins_fetcher_pkg
//   Shared constants for the instruction fetcher: default cache geometry,
//   default reset PC and the fetch-state encoding.
package ins_fetcher_pkg;

   localparam int          ICACHE_IDX_BIT_DEF = 6;
   localparam logic [31:0] RESET_PC_DEF       = 32'h0000_0000;

   localparam logic [1:0] FETCH_LOOKUP = 2'd0;
   localparam logic [1:0] FETCH_HOLD   = 2'd1;
   localparam logic [1:0] FETCH_MISS   = 2'd2;

   typedef enum logic [1:0] {
      ST_LOOKUP = FETCH_LOOKUP,
      ST_HOLD   = FETCH_HOLD,
      ST_MISS   = FETCH_MISS
   } fetch_state_t;

endpackage

// File: rtl/ins_fetcher_if.sv
// ins_fetcher_if
//   Bundles the decoder handshake, ROB redirect and memory-controller fetch
//   request seen by the fetcher.
//   master : fetcher side (drives inst_*, mem_req/mem_addr)
//   slave  : decoder / ROB / memory-controller side
interface ins_fetcher_if;
   import ins_fetcher_pkg::*;

   logic        inst_input;
   logic [31:0] inst;
   logic [31:0] inst_addr;
   logic        is_stall;
   logic [31:0] next_PC;

   logic        rob_clear;
   logic [31:0] rob_clear_pc;

   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done;
   logic [31:0] mem_data;

   modport master (
      output inst_input, inst, inst_addr, mem_req, mem_addr,
      input  is_stall, next_PC, rob_clear, rob_clear_pc, mem_done, mem_data
   );

   modport slave (
      input  inst_input, inst, inst_addr, mem_req, mem_addr,
      output is_stall, next_PC, rob_clear, rob_clear_pc, mem_done, mem_data
   );

endinterface

// File: rtl/ins_fetcher_icache_dm.sv
// icache_dm
//   Direct-mapped instruction cache, one 32-bit word per line.
//   clk_in, rst_in      : clock, synchronous active-low reset (clears valid bits)
//   rd_idx, rd_tag      : lookup address split into index/tag
//   rd_hit, rd_data     : combinational lookup result
//   we, wr_idx, wr_tag, wr_data : single fill port
module icache_dm
   import ins_fetcher_pkg::*;
#(
   parameter int IDX_BIT = ICACHE_IDX_BIT_DEF,
   localparam int LINES  = 1 << IDX_BIT,
   localparam int TAG_W  = 30 - IDX_BIT
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [IDX_BIT-1:0] rd_idx,
   input  logic [TAG_W-1:0]   rd_tag,
   output logic               rd_hit,
   output logic [31:0]        rd_data,
   input  logic               we,
   input  logic [IDX_BIT-1:0] wr_idx,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [31:0]        wr_data
);

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         valid_q <= '0;
      end else if (we) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // Tag/data need no reset; valid gates every use of them.
   always_ff @(posedge clk_in) begin
      if (rst_in && we) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_data;
      end
   end

   always_comb begin
      rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
      rd_data = data_q[rd_idx];
   end

endmodule

// File: rtl/ins_fetcher.sv
// ins_fetcher
//   Fetch front end: holds the PC, looks it up in a direct-mapped I-cache,
//   fetches misses through the memory controller and offers one instruction
//   at a time to the decoder. rob_clear redirects the PC.
//   clk_in  : clock
//   rst_in  : synchronous active-low reset
//   rdy_in  : global ready; low freezes every register
//   bus     : decoder / ROB / memory handshake (ins_fetcher_if.master)
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   LOOKUP | probe cache with pc; hit -> offer inst, miss -> request mem
//   HOLD   | inst valid to decoder until accepted (or flushed)
//   MISS   | mem_req held until mem_done; discard marks a flushed fetch
module ins_fetcher
   import ins_fetcher_pkg::*;
#(
   parameter int          ICACHE_IDX_BIT = ICACHE_IDX_BIT_DEF,
   parameter logic [31:0] RESET_PC       = RESET_PC_DEF,
   localparam int         TAG_W          = 30 - ICACHE_IDX_BIT
) (
   input  logic           clk_in,
   input  logic           rst_in,
   input  logic           rdy_in,
   ins_fetcher_if.master  bus
);

   fetch_state_t state_q, state_nxt;
   logic [31:0]  pc_q, pc_nxt;
   logic         discard_q, discard_nxt;
   logic         inst_input_q, inst_input_nxt;
   logic [31:0]  inst_q, inst_nxt;
   logic [31:0]  inst_addr_q, inst_addr_nxt;
   logic         mem_req_q, mem_req_nxt;
   logic [31:0]  mem_addr_q, mem_addr_nxt;

   logic         hit;
   logic [31:0]  hit_data;
   logic         fill_we;
   logic         accept;
   logic         fill_done;

   assign accept    = inst_input_q && !bus.is_stall;
   assign fill_done = (state_q == ST_MISS) && bus.mem_done;
   assign fill_we   = fill_done && rdy_in;

   icache_dm #(
      .IDX_BIT (ICACHE_IDX_BIT)
   ) u_icache (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .rd_idx  (pc_q[ICACHE_IDX_BIT+1:2]),
      .rd_tag  (pc_q[31:ICACHE_IDX_BIT+2]),
      .rd_hit  (hit),
      .rd_data (hit_data),
      .we      (fill_we),
      .wr_idx  (mem_addr_q[ICACHE_IDX_BIT+1:2]),
      .wr_tag  (mem_addr_q[31:ICACHE_IDX_BIT+2]),
      .wr_data (bus.mem_data)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q      <= ST_LOOKUP;
         pc_q         <= RESET_PC;
         discard_q    <= 1'b0;
         inst_input_q <= 1'b0;
         inst_q       <= '0;
         inst_addr_q  <= '0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
      end else if (rdy_in) begin
         state_q      <= state_nxt;
         pc_q         <= pc_nxt;
         discard_q    <= discard_nxt;
         inst_input_q <= inst_input_nxt;
         inst_q       <= inst_nxt;
         inst_addr_q  <= inst_addr_nxt;
         mem_req_q    <= mem_req_nxt;
         mem_addr_q   <= mem_addr_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_LOOKUP: begin
            if (bus.rob_clear) state_nxt = ST_LOOKUP;
            else if (hit)      state_nxt = ST_HOLD;
            else               state_nxt = ST_MISS;
         end
         ST_HOLD: begin
            if (bus.rob_clear || accept) state_nxt = ST_LOOKUP;
         end
         ST_MISS: begin
            if (bus.mem_done) begin
               state_nxt = (discard_q || bus.rob_clear) ? ST_LOOKUP : ST_HOLD;
            end
         end
         default: state_nxt = ST_LOOKUP;
      endcase
   end

   always_comb begin
      pc_nxt         = pc_q;
      discard_nxt    = discard_q;
      inst_input_nxt = inst_input_q;
      inst_nxt       = inst_q;
      inst_addr_nxt  = inst_addr_q;
      mem_req_nxt    = mem_req_q;
      mem_addr_nxt   = mem_addr_q;

      case (state_q)
         ST_LOOKUP: begin
            if (!bus.rob_clear) begin
               if (hit) begin
                  inst_nxt       = hit_data;
                  inst_addr_nxt  = pc_q;
                  inst_input_nxt = 1'b1;
               end else begin
                  mem_req_nxt  = 1'b1;
                  mem_addr_nxt = pc_q;
               end
            end
         end
         ST_HOLD: begin
            if (!bus.rob_clear && accept) begin
               pc_nxt         = bus.next_PC;
               inst_input_nxt = 1'b0;
            end
         end
         ST_MISS: begin
            if (bus.mem_done) begin
               mem_req_nxt = 1'b0;
               discard_nxt = 1'b0;
               if (!discard_q && !bus.rob_clear) begin
                  inst_nxt       = bus.mem_data;
                  inst_addr_nxt  = mem_addr_q;
                  inst_input_nxt = 1'b1;
               end
            end else if (bus.rob_clear) begin
               // The request cannot be withdrawn; drop its result instead.
               discard_nxt = 1'b1;
            end
         end
         default: ;
      endcase

      if (bus.rob_clear) begin
         pc_nxt         = bus.rob_clear_pc;
         inst_input_nxt = 1'b0;
      end
   end

   assign bus.inst_input = inst_input_q;
   assign bus.inst       = inst_q;
   assign bus.inst_addr  = inst_addr_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_addr   = mem_addr_q;

endmodule
